// File: rtl/index_pkg.sv
// Shared width helpers for the index packer slice.
// The packed word struct is declared in the instantiating module, because its widths depend on that module's parameters.
package index_pkg;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/index_pack_fifo.sv
// Generic synchronous FIFO with a zeroed read port when empty.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module index_pack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // The storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/index_packer.sv
// Packs a stream of set-bit indices into multi-lane words.
// Finished words are queued in a small FIFO toward a valid/ready consumer.
module index_packer
    import index_pkg::*;
#(
    parameter int N     = 8,
    parameter int PACK  = 4,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [idx_w(N)-1:0]           in_index,
    input  logic                          in_last,
    input  logic                          in_none,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PACK*idx_w(N)-1:0]      out_data,
    output logic [cnt_w(PACK)-1:0]        out_count,
    output logic                          out_last
);
    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(PACK);

    typedef struct packed {
        logic             last;
        logic [CW-1:0]    count;
        logic [PACK*IW-1:0] data;
    } word_t;

    logic [PACK-1:0][IW-1:0] lanes_q, lanes_d, lanes_new;
    logic [CW-1:0]           acc_cnt_q, acc_cnt_d;
    word_t                   push_word, head_word;
    logic                    accept, close, push;
    logic                    fifo_full, fifo_empty;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && close;

    // An in_none beat closes the current word as-is; otherwise the new index fills lane acc_cnt.
    always_comb begin
        lanes_new = lanes_q;
        for (int k = 0; k < PACK; k++) begin
            if (!in_none && (CW'(k) == acc_cnt_q)) lanes_new[k] = in_index;
        end

        push_word = '0;
        close     = 1'b0;
        if (in_none) begin
            push_word.data  = lanes_q;
            push_word.count = acc_cnt_q;
            push_word.last  = 1'b1;
            close           = 1'b1;
        end else begin
            push_word.data  = lanes_new;
            push_word.count = acc_cnt_q + CW'(1);
            push_word.last  = in_last;
            close           = in_last || (acc_cnt_q == CW'(PACK - 1));
        end

        acc_cnt_d = acc_cnt_q;
        lanes_d   = lanes_q;
        if (accept) begin
            if (close) begin
                acc_cnt_d = '0;
                lanes_d   = '0;
            end else begin
                acc_cnt_d = acc_cnt_q + CW'(1);
                lanes_d   = lanes_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_cnt_q <= '0;
            lanes_q   <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            lanes_q   <= lanes_d;
        end
    end

    index_pack_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (out_ready),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_word.data;
    assign out_count = head_word.count;
    assign out_last  = head_word.last;

    a_index_in_range: assert property (@(posedge clk) disable iff (!rstn)
        (in_valid && in_ready && !in_none) |-> (32'(in_index) < N));

endmodule

// File: tb/tb_index_packer.sv
// Directed bench for index_packer: each task drives one scenario and checks inline.
// Expected words are hand-computed from lane k = bits [3k +: 3].
module tb_index_packer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_index;
    logic        in_last;
    logic        in_none;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [2:0]  out_count;
    logic        out_last;

    int vectors = 0;
    int errors  = 0;

    index_packer #(.N(8), .PACK(4), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_last   (in_last),
        .in_none   (in_none),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Called #1 after a rising edge; returns #1 after the edge on which the beat was accepted.
    task automatic drive_beat(input logic [2:0] idx, input logic last, input logic none);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_index = idx;
        in_last  = last;
        in_none  = none;
        while (!in_ready && waitCycles < 50) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL beat_accept idx=%0d: in_ready=%b, required 1 within 50 cycles", idx, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_none  = 1'b0;
        in_index = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_valid = 1'b0; in_index = '0; in_last = 1'b0; in_none = 1'b0; out_ready = 1'b0;
        #12;
        vectors++;
        if ({in_ready, out_valid, out_last, out_count, out_data} !== {1'b1, 1'b0, 1'b0, 3'd0, 12'h000}) begin
            errors++;
            $display("[TB] FAIL reset_values: ready=%b valid=%b last=%b count=%0d data=%h, required 1 0 0 0 000",
                     in_ready, out_valid, out_last, out_count, out_data);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sparse_vector();
        out_ready = 1'b1;
        drive_beat(3'd2, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sparse_no_early_word: out_valid=%b, required 0", out_valid);
        end
        drive_beat(3'd3, 1'b0, 1'b0);
        drive_beat(3'd7, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b1, 3'd3, 12'h1DA}) begin
            errors++;
            $display("[TB] FAIL sparse_word: valid=%b last=%b count=%0d data=%h, required 1 1 3 1da",
                     out_valid, out_last, out_count, out_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_last, out_count, out_data} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL empty_outputs_zero: valid=%b last=%b count=%0d data=%h, required 0 0 0 000",
                     out_valid, out_last, out_count, out_data);
        end
    endtask

    task automatic test_full_vector();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_beat(3'(i), (i == 7), 1'b0);
            if (i == 3) begin
                vectors++;
                if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b0, 3'd4, 12'h688}) begin
                    errors++;
                    $display("[TB] FAIL full_word1: valid=%b last=%b count=%0d data=%h, required 1 0 4 688",
                             out_valid, out_last, out_count, out_data);
                end
            end
            if (i == 7) begin
                vectors++;
                if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b1, 3'd4, 12'hFAC}) begin
                    errors++;
                    $display("[TB] FAIL full_word2: valid=%b last=%b count=%0d data=%h, required 1 1 4 fac",
                             out_valid, out_last, out_count, out_data);
                end
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_no_extra_word: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_none();
        out_ready = 1'b1;
        drive_beat(3'd5, 1'b0, 1'b1);
        vectors++;
        if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b1, 3'd0, 12'h000}) begin
            errors++;
            $display("[TB] FAIL none_word: valid=%b last=%b count=%0d data=%h, required 1 1 0 000",
                     out_valid, out_last, out_count, out_data);
        end
        @(posedge clk);
        #1;
        drive_beat(3'd0, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b1, 3'd1, 12'h000}) begin
            errors++;
            $display("[TB] FAIL index0_word: valid=%b last=%b count=%0d data=%h, required 1 1 1 000",
                     out_valid, out_last, out_count, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int got = 0;
        int cyc = 0;
        logic acceptNow;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) drive_beat(3'(k), 1'b1, 1'b0);
        vectors++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL fifo_full_ready: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        in_valid = 1'b1; in_index = 3'd5; in_last = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({in_ready, out_data, out_count} !== {1'b0, 12'h001, 3'd1}) begin
            errors++;
            $display("[TB] FAIL stall_hold: in_ready=%b data=%h count=%0d, required 0 001 1", in_ready, out_data, out_count);
        end
        out_ready = 1'b1;
        while (got < 5 && cyc < 30) begin
            if (out_valid) begin
                vectors++;
                if ({out_last, out_count, out_data} !== {1'b1, 3'd1, 12'(got + 1)}) begin
                    errors++;
                    $display("[TB] FAIL drain_word%0d: last=%b count=%0d data=%h, required 1 1 %h",
                             got + 1, out_last, out_count, out_data, 12'(got + 1));
                end
                got++;
            end
            acceptNow = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acceptNow) begin
                in_valid = 1'b0; in_last = 1'b0; in_index = '0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got !== 5) begin
            errors++;
            $display("[TB] FAIL drain_count: words=%0d, required 5", got);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_beat(3'd1, 1'b1, 1'b0);
        drive_beat(3'd6, 1'b0, 1'b0);
        drive_beat(3'd5, 1'b0, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_last, out_count, out_data} !== {1'b1, 1'b0, 1'b0, 3'd0, 12'h000}) begin
            errors++;
            $display("[TB] FAIL async_reset: ready=%b valid=%b last=%b count=%0d data=%h, required 1 0 0 0 000",
                     in_ready, out_valid, out_last, out_count, out_data);
        end
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_beat(3'd4, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b1, 3'd1, 12'h004}) begin
            errors++;
            $display("[TB] FAIL post_reset_word: valid=%b last=%b count=%0d data=%h, required 1 1 1 004",
                     out_valid, out_last, out_count, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic acceptNow;
        logic [11:0] expData;
        out_ready = 1'b0;
        drive_beat(3'd3, 1'b1, 1'b0);
        out_ready = 1'b1;
        drive_beat(3'd6, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, out_last, out_count, out_data} !== {1'b1, 1'b1, 3'd1, 12'h006}) begin
            errors++;
            $display("[TB] FAIL pushpop_head: valid=%b last=%b count=%0d data=%h, required 1 1 1 006",
                     out_valid, out_last, out_count, out_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pushpop_occupancy: out_valid=%b, required 0", out_valid);
        end
        // Stream 3*DEPTH words with a stuttering consumer so the pointers wrap several times.
        while (got < 3 * DEPTH && cyc < 200) begin
            out_ready = ((cyc % 3) != 2);
            if (sent < 3 * DEPTH) begin
                in_valid = 1'b1; in_last = 1'b1; in_index = 3'((3 * sent + 1) % 8);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            if (out_valid) begin
                expData = 12'((3 * got + 1) % 8);
                vectors++;
                if ({out_last, out_count, out_data} !== {1'b1, 3'd1, expData}) begin
                    errors++;
                    $display("[TB] FAIL wrap_word%0d: last=%b count=%0d data=%h, required 1 1 %h",
                             got, out_last, out_count, out_data, expData);
                end
                if (out_ready) got++;
            end
            acceptNow = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acceptNow) sent++;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({got, out_valid} !== {32'(3 * DEPTH), 1'b0}) begin
            errors++;
            $display("[TB] FAIL wrap_total: words=%0d valid=%b, required %0d 0", got, out_valid, 3 * DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_sparse_vector();
        test_full_vector();
        test_none();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
